seq_fixed_mul: RTL and testbench
================================

Name: seq_fixed_mul

Overview:
Multi-cycle signed fixed-point multiplier. It is the responder side of the start/done arithmetic handshake that the sliding-DFT update sequencers use to request products, for example bin × twiddle. It replaces a single-cycle DSP product with a radix-2 shift-add datapath: one operand pair per request, a one-cycle done pulse, and a held registered result. Port order matches the existing arithmetic-unit instantiation convention: clk, operand A, operand B, start, answer, done.

Parameters:
WIDTH, 24, operand and result width (two's complement).
FRAC, 12, fractional bits of the Q format (default Q12.12; 1.0 = 0x001000).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
a  input  WIDTH  multiplicand, sampled only on the accepting edge
b  input  WIDTH  multiplier, sampled only on the accepting edge
start  input  1  request; accepted only in IDLE
answer  output  WIDTH  registered product, held until the next completion
done  output  1  one-cycle pulse; answer is valid while high and afterwards
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-operation:
  - state=IDLE, answer=0, done=0, busy=0, counter=0, accumulators cleared.
  - An in-flight result is discarded.
- States: IDLE, MUL, NORM, DONE.
- IDLE:
  - If start=1 at an edge, latch |a| and |b| as unsigned WIDTH-bit magnitudes.
  - |0x800000| = 0x800000, with no overflow in magnitude form.
  - Latch sign = a[W-1]^b[W-1], clear the 2W-bit accumulator, load the counter with WIDTH, go to MUL.
- MUL: one iteration per cycle, for exactly WIDTH cycles.
  - If the multiplier-magnitude LSB is 1, add the multiplicand magnitude into the accumulator.
  - Then shift the multiplier right and the multiplicand left (or the equivalent accumulator shift).
  - Decrement the counter; at 0 go to NORM.
- NORM: one cycle.
  - mag = (acc + 2^(FRAC-1)) >> FRAC, i.e. round half away from zero, because rounding is applied to the magnitude.
  - Saturate: if sign=0 and mag > 2^(W-1)-1, answer = 0x7FFFFF.
  - If sign=1 and mag > 2^(W-1), answer = 0x800000.
  - Otherwise answer = sign ? -mag : mag.
  - A zero product gives 0 regardless of sign; never output a negative zero pattern.
  - answer register updates on the NORM→DONE edge. Go to DONE.
- DONE: done=1 for exactly this one cycle, then return to IDLE.
- Latency: start sampled at edge E0 → done high in the cycle between edges E0+WIDTH+1 and E0+WIDTH+2.
  - That is 25 cycles after acceptance for WIDTH=24.
  - Minimum request spacing is WIDTH+3 cycles.
- start while busy=1 (MUL/NORM/DONE) is ignored and not queued. Operand changes during MUL do not affect the result.
- start held high continuously causes a new acceptance on the first IDLE edge after DONE.
- Between completions, answer holds its value. done is never asserted without a preceding acceptance.

Test Plan:
- Reset, then a=0x002000 (2.0), b=0x003000 (3.0), start pulsed 1 cycle → done pulses exactly once, 25 cycles after the accept edge, answer=0x006000; busy low again the cycle after done.
- a=0xFFE800 (−1.5), b=0x000800 (0.5) → answer=0xFFF400 (−0.75); a=0x000000, b=0xFFF000 → answer=0x000000.
- Rounding: a=0x000001, b=0x000800 → answer=0x000001; a=0xFFFFFF, b=0x000800 → answer=0xFFFFFF; a=0x000001, b=0x0007FF → answer=0x000000.
- Saturation: 0x7FFFFF×0x7FFFFF → 0x7FFFFF; 0x800000×0x7FFFFF → 0x800000; 0x800000×0x800000 → 0x7FFFFF.
- Start 5 cycles after acceptance with different operands, and operands changed mid-MUL → ignored; single done with the first pair's product; subsequent start in IDLE accepted normally.
- rst asserted 10 cycles into MUL → next cycle state IDLE, answer=0, done=0, busy=0, no done pulse follows; a fresh request then completes with correct latency.

Source files
------------

// File: rtl/seq_fixed_mul_if.sv
// Start/done arithmetic handshake between a requesting sequencer (master)
// and a multi-cycle arithmetic responder (slave).
interface seq_fixed_mul_if #(
    parameter int unsigned WIDTH = 24
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic [WIDTH-1:0] answer;
    logic             done;
    logic             busy;

    modport master (
        output a,
        output b,
        output start,
        input  answer,
        input  done,
        input  busy
    );

    modport slave (
        input  a,
        input  b,
        input  start,
        output answer,
        output done,
        output busy
    );
endinterface

// File: rtl/seq_fixed_mul.sv
// Multi-cycle signed Q-format multiplier: radix-2 shift-add on operand
// magnitudes, then round-half-away-from-zero, saturation and sign restore.
module seq_fixed_mul #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned FRAC  = 12
) (
    input  logic           clk,
    input  logic           rst,
    seq_fixed_mul_if.slave bus
);
    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [AW-1:0] ROUND   = AW'(64'(1) << (FRAC - 1));
    localparam logic [AW-1:0] POS_MAX = AW'((64'(1) << (WIDTH - 1)) - 64'(1));
    localparam logic [AW-1:0] NEG_MAX = AW'(64'(1) << (WIDTH - 1));

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mplier;
    logic [AW-1:0]    mcand;
    logic [AW-1:0]    acc;
    logic             sign;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] answer_q;

    logic [AW-1:0]    rounded;
    logic [AW-1:0]    mag;
    logic [WIDTH-1:0] mag_w;
    logic [WIDTH-1:0] norm_result;

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = MUL;
            MUL:  if (cnt == CW'(1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Rounding on the magnitude gives round-half-away-from-zero once the
    // sign is restored; a zero magnitude negates to zero, never -0.
    always_comb begin
        rounded     = acc + ROUND;
        mag         = rounded >> FRAC;
        mag_w       = mag[WIDTH-1:0];
        norm_result = sign ? (~mag_w + WIDTH'(1)) : mag_w;
        if (!sign && (mag > POS_MAX)) begin
            norm_result = SAT_POS;
        end else if (sign && (mag > NEG_MAX)) begin
            norm_result = SAT_NEG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
            sign     <= 1'b0;
            cnt      <= '0;
            answer_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= AW'(magnitude(bus.a));
                        mplier <= magnitude(bus.b);
                        sign   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                end
                NORM: begin
                    answer_q <= norm_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.answer = answer_q;
    assign bus.done   = (state == DONE);
    assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_seq_fixed_mul.sv
// Self-checking bench for seq_fixed_mul: vector table plus hand-written
// multi-cycle sequences, with a queue scoreboard checking result and latency.
module tb_seq_fixed_mul;
    localparam int unsigned WIDTH   = 24;
    localparam int unsigned FRAC    = 12;
    localparam int          LATENCY = WIDTH + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_fixed_mul_if #(.WIDTH(WIDTH)) bus ();

    seq_fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] exp;
        int               acc_cyc;
    } sb_t;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    sb_t  sb[$];
    int   cyc       = 0;
    int   done_seen = 0;
    int   errors    = 0;
    int   checks    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse pops one expected entry.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            sb_t e;
            done_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("answer", 64'(bus.answer), 64'(e.exp));
                chk("latency", 64'(cyc - e.acc_cyc), 64'(LATENCY));
            end
        end
    end

    // Drives one request at a negedge; returns at #1 after the accept edge.
    task automatic start_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] exp, input bit hold);
        sb_t e;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e.exp     = exp;
        e.acc_cyc = cyc;
        sb.push_back(e);
        chk("busy_after_accept", 64'(bus.busy), 64'(1));
        if (!hold) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic wait_done(input int n0, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (done_seen > n0) return;
        end
        chk("done_timeout", 64'(done_seen), 64'(n0 + 1));
    endtask

    task automatic run_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp);
        int n0;
        n0 = done_seen;
        start_req(a, b, exp, 1'b0);
        wait_done(n0, LATENCY + 10);
        @(negedge clk);
        chk("busy_after_done", 64'(bus.busy), 64'(0));
        chk("done_pulse_width", 64'(bus.done), 64'(0));
    endtask

    vec_t vecs[$];

    initial begin
        int n0;
        int e0;
        sb_t e;

        vecs.push_back('{"int_mul",   24'h002000, 24'h003000, 24'h006000});
        vecs.push_back('{"neg_half",  24'hFFE800, 24'h000800, 24'hFFF400});
        vecs.push_back('{"zero_neg",  24'h000000, 24'hFFF000, 24'h000000});
        vecs.push_back('{"rnd_up",    24'h000001, 24'h000800, 24'h000001});
        vecs.push_back('{"rnd_neg",   24'hFFFFFF, 24'h000800, 24'hFFFFFF});
        vecs.push_back('{"rnd_down",  24'h000001, 24'h0007FF, 24'h000000});
        vecs.push_back('{"sat_pp",    24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF});
        vecs.push_back('{"sat_np",    24'h800000, 24'h7FFFFF, 24'h800000});
        vecs.push_back('{"sat_nn",    24'h800000, 24'h800000, 24'h7FFFFF});
        vecs.push_back('{"neg_edge",  24'h800000, 24'h001000, 24'h800000});
        vecs.push_back('{"pos_edge",  24'h800000, 24'hFFF000, 24'h7FFFFF});
        vecs.push_back('{"neg_neg",   24'hFFF000, 24'hFFF000, 24'h001000});
        vecs.push_back('{"small_neg", 24'hFFF000, 24'h000001, 24'hFFFFFF});

        bus.a     = '0;
        bus.b     = '0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_answer", 64'(bus.answer), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_busy", 64'(bus.busy), 64'(0));

        foreach (vecs[i]) begin
            run_req(vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Start while busy and operand changes mid-MUL are both ignored.
        n0 = done_seen;
        start_req(24'h001800, 24'h002000, 24'h003000, 1'b0);
        repeat (3) @(negedge clk);
        bus.a     = 24'h7FFFFF;
        bus.b     = 24'h7FFFFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.a = WIDTH'($urandom);
            bus.b = WIDTH'($urandom);
        end
        wait_done(n0, LATENCY + 10);
        repeat (LATENCY + 5) @(negedge clk);
        chk("single_done", 64'(done_seen - n0), 64'(1));
        chk("sb_empty", 64'(sb.size()), 64'(0));
        run_req(24'h000800, 24'h000800, 24'h000400);

        // Start held high: re-accepted on the first IDLE edge after DONE.
        n0 = done_seen;
        start_req(24'h003000, 24'h001000, 24'h003000, 1'b1);
        e0 = cyc;
        bus.a = 24'hFFD000;
        bus.b = 24'h002000;
        wait_done(n0, LATENCY + 10);
        e.exp     = 24'hFFA000;
        e.acc_cyc = e0 + WIDTH + 3;
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("held_reaccept_busy", 64'(bus.busy), 64'(1));
        wait_done(n0 + 1, LATENCY + 10);
        @(negedge clk);
        chk("held_busy_after", 64'(bus.busy), 64'(0));

        // Reset ten cycles into MUL discards the in-flight product.
        start_req(24'h002000, 24'h002000, 24'h004000, 1'b0);
        void'(sb.pop_back());
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_answer", 64'(bus.answer), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        n0 = done_seen;
        repeat (LATENCY + 10) @(negedge clk);
        chk("no_done_after_rst", 64'(done_seen), 64'(n0));
        run_req(24'h001000, 24'h001000, 24'h001000);

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "simulation time limit exceeded");
    end
endmodule
